// File: rtl/i2s_tx_ctrl_pkg.sv
// Shared definitions for the I2S transmit controller: FSM states, frame geometry
// and the sample formatting helper.
package i2s_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } i2s_state_e;

  localparam int FRAME_SLOTS = 32;
  localparam int SLOT_W      = $clog2(FRAME_SLOTS);
  localparam int SAMPLE_W    = 16;

  // Offset-binary to two's complement is just an MSB flip.
  function automatic logic [SAMPLE_W-1:0] i2s_fmt(input logic [SAMPLE_W-1:0] w,
                                                  input logic              inv_msb);
    return {w[SAMPLE_W-1] ^ inv_msb, w[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides the system clock by 2*DIV while enabled and
// flags the cycle whose closing edge raises or lowers BCLK.
module i2s_bclk_gen #(
  parameter int DIV = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic bc,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int              CW      = $clog2(DIV);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bc_q, bc_d;
  logic          wrap;

  assign wrap = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    bc_d  = bc_q;
    if (!en) begin
      cnt_d = '0;
      bc_d  = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      bc_d  = ~bc_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
      bc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bc_q  <= bc_d;
    end
  end

  assign bc       = bc_q;
  assign fall_stb = en & wrap & bc_q;
  assign rise_stb = en & wrap & ~bc_q;

endmodule

// File: rtl/i2s_tx_ctrl.sv
// Philips I2S transmitter: captures one stereo sample per 32-slot frame and
// shifts it out MSB-first, one BCLK after each word-select change.
module i2s_tx_ctrl
  import i2s_tx_ctrl_pkg::*;
#(
  parameter int DIV      = 16,
  parameter bit UNSIGNED = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] l_data,
  input  logic [SAMPLE_W-1:0] r_data,
  output logic                sample_stb,
  output logic                busy,
  output logic                i2s_bc,
  output logic                i2s_lc,
  output logic                i2s_dt
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_SLOTS - 1);

  i2s_state_e              state_q, state_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic                    lc_q, lc_d;
  logic [2*SAMPLE_W-1:0]   shift_q, shift_d;
  logic [SAMPLE_W-1:0]     hold_l_q, hold_l_d;
  logic [SAMPLE_W-1:0]     hold_r_q, hold_r_d;
  logic                    stb_q, stb_d;

  logic bclk_en;
  logic bc;
  logic fall_stb;
  logic bclk_rise_unused;

  assign bclk_en = (state_q != ST_IDLE);

  i2s_bclk_gen #(
    .DIV (DIV)
  ) u_bclk (
    .clock    (clock),
    .reset    (reset),
    .en       (bclk_en),
    .bc       (bc),
    .fall_stb (fall_stb),
    .rise_stb (bclk_rise_unused)
  );

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    lc_d     = lc_q;
    shift_d  = shift_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    stb_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        slot_d  = '0;
        lc_d    = 1'b0;
        shift_d = '0;
        if (en) begin
          state_d  = ST_RUN;
          hold_l_d = l_data;
          hold_r_d = r_data;
          stb_d    = 1'b1;
        end
      end

      ST_RUN, ST_DRAIN: begin
        if (state_q == ST_RUN && !en) begin
          state_d = ST_DRAIN;
        end
        if (fall_stb) begin
          slot_d = slot_q + 1'b1;
          lc_d   = slot_d[SLOT_W-1];
          // Slot 0 still carries the previous frame's R LSB, so reload on leaving it.
          if (slot_q == '0) begin
            shift_d = {i2s_fmt(hold_l_q, UNSIGNED), i2s_fmt(hold_r_q, UNSIGNED)};
          end else begin
            shift_d = shift_q << 1;
          end
          if (slot_q == LAST_SLOT && state_q == ST_RUN && en) begin
            hold_l_d = l_data;
            hold_r_d = r_data;
            stb_d    = 1'b1;
          end
          if (state_q == ST_DRAIN && slot_q == '0) begin
            state_d = ST_IDLE;
            slot_d  = '0;
            lc_d    = 1'b0;
            shift_d = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      slot_q   <= '0;
      lc_q     <= 1'b0;
      shift_q  <= '0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      stb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      lc_q     <= lc_d;
      shift_q  <= shift_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      stb_q    <= stb_d;
    end
  end

  assign sample_stb = stb_q;
  assign busy       = (state_q != ST_IDLE);
  assign i2s_bc     = bc;
  assign i2s_lc     = lc_q;
  assign i2s_dt     = shift_q[2*SAMPLE_W-1];

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Bench for i2s_tx_ctrl: two instances (two's complement and offset-binary) share
// stimulus and are checked every cycle against a frame-timing model.
module tb_i2s_tx_ctrl;

  localparam int DIV       = 16;
  localparam int SLOT_CLKS = 2 * DIV;
  localparam int FRAME     = 64 * DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en    = 1'b0;
  logic [15:0] l_data = 16'h0;
  logic [15:0] r_data = 16'h0;
  logic [1:0]  stb_o, busy_o, bc_o, lc_o, dt_o;

  i2s_tx_ctrl #(.DIV(DIV), .UNSIGNED(1'b0)) u_dut0 (
    .clock(clock), .reset(reset), .en(en), .l_data(l_data), .r_data(r_data),
    .sample_stb(stb_o[0]), .busy(busy_o[0]), .i2s_bc(bc_o[0]), .i2s_lc(lc_o[0]), .i2s_dt(dt_o[0])
  );

  i2s_tx_ctrl #(.DIV(DIV), .UNSIGNED(1'b1)) u_dut1 (
    .clock(clock), .reset(reset), .en(en), .l_data(l_data), .r_data(r_data),
    .sample_stb(stb_o[1]), .busy(busy_o[1]), .i2s_bc(bc_o[1]), .i2s_lc(lc_o[1]), .i2s_dt(dt_o[1])
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit started = 1'b0;

  // Model: n = clocks since the run began; everything else follows from n.
  bit          m_act = 1'b0, m_drn = 1'b0, m_stb = 1'b0, m_have_prev = 1'b0;
  int          m_n = 0;
  logic [15:0] m_cl = '0, m_cr = '0, m_pl = '0, m_pr = '0;

  function automatic logic [15:0] fm(input logic [15:0] w, input bit u);
    return u ? (w ^ 16'h8000) : w;
  endfunction

  // Expected {sample_stb, busy, bc, lc, dt} for instance i.
  function automatic logic [4:0] exp_vec(input int i);
    logic [31:0] wd;
    logic [4:0]  v;
    int          slot;
    if (!m_act) return 5'b0;
    slot = (m_n / SLOT_CLKS) % 32;
    v[4] = m_stb;
    v[3] = 1'b1;
    v[2] = ((m_n / DIV) % 2) == 1;
    v[1] = (slot >= 16);
    if (slot == 0) begin
      wd   = {fm(m_pl, i == 1), fm(m_pr, i == 1)};
      v[0] = m_have_prev & wd[0];
    end else begin
      wd   = {fm(m_cl, i == 1), fm(m_cr, i == 1)};
      v[0] = wd[32 - slot];
    end
    return v;
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
    m_stb = 1'b0;
    if (!reset) begin
      m_act = 1'b0;
      m_drn = 1'b0;
    end else if (!m_act) begin
      if (en) begin
        m_act = 1'b1; m_drn = 1'b0; m_n = 0;
        m_cl = l_data; m_cr = r_data; m_have_prev = 1'b0; m_stb = 1'b1;
      end
    end else if (m_drn && (m_n % FRAME) == SLOT_CLKS - 1) begin
      m_act = 1'b0;
    end else begin
      if (!en) m_drn = 1'b1;
      m_n++;
      if (m_n % FRAME == 0) begin
        m_pl = m_cl; m_pr = m_cr; m_have_prev = 1'b1;
        if (!m_drn) begin
          m_cl = l_data; m_cr = r_data; m_stb = 1'b1;
        end
      end
    end
    started = 1'b1;
  end

  // Per-cycle compare plus an I2S receiver that decodes each completed frame.
  logic [1:0]  bc_prev = '0, lc_prev = '0;
  logic [31:0] rx [2];
  logic [15:0] dec_l [2];
  logic [15:0] dec_r [2];
  int          dec_n [2];
  int          stb_cnt = 0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rx[i] = '0; dec_l[i] = '0; dec_r[i] = '0; dec_n[i] = 0;
    end
  end

  initial forever begin
    @(negedge clock);
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        logic [4:0]  e, a;
        logic [31:0] wd;
        e = exp_vec(i);
        a = {stb_o[i], busy_o[i], bc_o[i], lc_o[i], dt_o[i]};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_cmp dut%0d cyc %0d: stb/busy/bc/lc/dt got %b want %b", i, cyc, a, e);
        end
        if (busy_o[i] !== 1'b1) begin
          bc_prev[i] = 1'b0; lc_prev[i] = 1'b0; rx[i] = '0;
        end else begin
          if (bc_o[i] && !bc_prev[i]) begin
            rx[i] = {rx[i][30:0], dt_o[i]};
            if (lc_prev[i] && !lc_o[i]) begin
              wd = {fm(m_pl, i == 1), fm(m_pr, i == 1)};
              dec_l[i] = rx[i][31:16];
              dec_r[i] = rx[i][15:0];
              dec_n[i]++;
              checks++;
              if (rx[i] !== wd) begin
                errors++;
                $display("FAIL frame_word dut%0d cyc %0d: got %h want %h", i, cyc, rx[i], wd);
              end
            end
            lc_prev[i] = lc_o[i];
          end
          bc_prev[i] = bc_o[i];
        end
        if (i == 0 && stb_o[0] === 1'b1) stb_cnt++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // kind 0: bc rise, 1: lc rise, 2: sample_stb, 3: busy low (all on dut0)
  int ev_t = 0;
  task automatic wait_ev(input int kind, input int budget, input string name);
    bit   hit;
    logic pb, pl;
    hit = 1'b0;
    pb  = bc_o[0];
    pl  = lc_o[0];
    for (int k = 0; k < budget && !hit; k++) begin
      @(negedge clock);
      case (kind)
        0:       hit = (bc_o[0] === 1'b1) && (pb === 1'b0);
        1:       hit = (lc_o[0] === 1'b1) && (pl === 1'b0);
        2:       hit = (stb_o[0] === 1'b1);
        default: hit = (busy_o[0] === 1'b0);
      endcase
      pb = bc_o[0];
      pl = lc_o[0];
    end
    ev_t = cyc;
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s: no event within %0d clocks", name, budget);
    end
  endtask

  initial begin
    int          t, t0, last, dn, sb;
    logic [15:0] cap_l, cap_r;

    // Reset held with en=1
    reset = 1'b0; en = 1'b1; l_data = 16'hA5C3; r_data = 16'h0F01;
    repeat (3) begin
      @(negedge clock);
      chk("t1_reset_outputs", {stb_o, busy_o, bc_o, lc_o, dt_o}, 32'h0);
    end
    reset = 1'b1;
    @(negedge clock);
    chk("t1_stb_after_release", stb_o, 2'b11);
    chk("t1_bc_low", bc_o, 2'b00);

    // Known words, clock periods
    wait_ev(0, 4 * DIV, "t2_bc_rise_a"); t = ev_t;
    wait_ev(0, 4 * DIV, "t2_bc_rise_b");
    chk("t2_bc_period", ev_t - t, 2 * DIV);
    wait_ev(1, 2 * FRAME, "t2_lc_rise_a"); t = ev_t;
    wait_ev(1, 2 * FRAME, "t2_lc_rise_b");
    chk("t2_lc_period", ev_t - t, FRAME);
    chk("t2_left_tc",   dec_l[0], 16'hA5C3);
    chk("t2_right_tc",  dec_r[0], 16'h0F01);
    chk("t2_left_ob",   dec_l[1], 16'h25C3);
    chk("t2_right_ob",  dec_r[1], 16'h8F01);

    // MSB-flip corner values
    l_data = 16'h8000; r_data = 16'h0000;
    repeat (3 * FRAME) @(negedge clock);
    chk("t3_left_tc",  dec_l[0], 16'h8000);
    chk("t3_right_tc", dec_r[0], 16'h0000);
    chk("t3_left_ob",  dec_l[1], 16'h0000);
    chk("t3_right_ob", dec_r[1], 16'h8000);

    // Data changing every clock: only the capture-cycle value is sent
    last = -1; cap_l = '0; cap_r = '0;
    for (int k = 0; k < 3 * FRAME + 8; k++) begin
      @(negedge clock);
      if (stb_o[0] === 1'b1) begin
        if (last >= 0) chk("t4_stb_spacing", cyc - last, FRAME);
        last  = cyc;
        cap_l = l_data;
        cap_r = r_data;
      end
      l_data = 16'($urandom);
      r_data = 16'($urandom);
    end
    wait_ev(2, 2 * FRAME, "t4_next_stb");
    repeat (2 * DIV) @(negedge clock);
    chk("t4_sent_left",    dec_l[0], cap_l);
    chk("t4_sent_right",   dec_r[0], cap_r);
    chk("t4_sent_left_ob", dec_l[1], cap_l ^ 16'h8000);

    // Drop en at slot 20: frame drains through slot 0 then idles
    l_data = 16'($urandom); r_data = 16'($urandom);
    wait_ev(2, 2 * FRAME, "t5_stb"); t0 = ev_t;
    repeat (20 * SLOT_CLKS + 4) @(negedge clock);
    sb = stb_cnt; dn = dec_n[0];
    en = 1'b0;
    wait_ev(3, 2 * FRAME, "t5_busy_low");
    chk("t5_idle_time",    ev_t - t0, FRAME + SLOT_CLKS);
    chk("t5_no_stb",       stb_cnt - sb, 0);
    chk("t5_drain_frames", dec_n[0] - dn, 1);
    chk("t5_right_sent",   dec_r[0], r_data);
    @(negedge clock);
    chk("t5_idle_outputs", {stb_o, busy_o, bc_o, lc_o, dt_o}, 32'h0);

    // Reset at slot 9, then a clean rerun with the known words
    en = 1'b1; l_data = 16'hA5C3; r_data = 16'h0F01;
    wait_ev(2, 4, "t6_stb");
    repeat (9 * SLOT_CLKS + 3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("t6_reset_outputs", {stb_o, busy_o, bc_o, lc_o, dt_o}, 32'h0);
    reset = 1'b1;
    dn = dec_n[0];
    @(negedge clock);
    chk("t6_restart_stb", stb_o, 2'b11);
    repeat (3 * FRAME) @(negedge clock);
    chk("t6_frames",   dec_n[0] - dn, 2);
    chk("t6_left_tc",  dec_l[0], 16'hA5C3);
    chk("t6_right_tc", dec_r[0], 16'h0F01);
    chk("t6_right_ob", dec_r[1], 16'h8F01);

    // Random drops, some with en re-raised while draining
    for (int it = 0; it < 4; it++) begin
      en = 1'b1;
      l_data = 16'($urandom); r_data = 16'($urandom);
      wait_ev(2, 2 * FRAME + 4, "rnd_stb");
      repeat ($urandom_range(1, FRAME)) @(negedge clock);
      en = 1'b0;
      if (it % 2 == 1) begin
        repeat ($urandom_range(1, 64)) @(negedge clock);
        en = 1'b1;
      end
      wait_ev(3, 3 * FRAME, "rnd_busy_low");
    end
    en = 1'b0;
    repeat (4) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
